// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, occupancy-width helper and beat type for elastic_pipeline
package pipe_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int DEPTH_DEF = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] data;
  } beat_t;
endpackage

// File: rtl/pipe_slice.sv
// pipe_slice: one elastic register slice; bubbles advance valid without touching data
module pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);
  // flush kills the beat but keeps data; a load only captures data for a real beat
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-slice valid/ready channel with flush; ELASTIC_PIPE_SKID_EN adds a skid entry with registered in_ready
module elastic_pipeline import pipe_pkg::*; #(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] prev_valid;
  logic [WIDTH-1:0] prev_data [DEPTH];
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             skid_valid_q;
  assign ready[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    assign ready[i] = ~valid_q[i] | ready[i+1];
    if (i == 0) begin : g_head
      assign prev_valid[i] = head_valid;
      assign prev_data[i]  = head_data;
    end else begin : g_link
      assign prev_valid[i] = valid_q[i-1];
      assign prev_data[i]  = data_q[i-1];
    end
    pipe_slice #(.WIDTH(WIDTH)) u_slice (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .load    (ready[i]),
      .valid_i (prev_valid[i]),
      .data_i  (prev_data[i]),
      .valid_q (valid_q[i]),
      .data_q  (data_q[i])
    );
  end
`ifdef ELASTIC_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q;
  assign in_ready   = ~skid_valid_q & ~flush;
  assign head_valid = skid_valid_q | (in_valid & in_ready);
  assign head_data  = skid_valid_q ? skid_data_q : in_data;
  // park a beat that slice 0 cannot take; release it as soon as slice 0 loads
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      skid_valid_q <= ~ready[0];
    end else if (in_valid & in_ready & ~ready[0]) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
    end
`else
  assign skid_valid_q = 1'b0;
  assign in_ready     = ready[0] & ~flush;
  assign head_valid   = in_valid;
  assign head_data    = in_data;
`endif
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  // occupancy is a popcount of the registered valid bits, so it follows them exactly
  always_comb begin
    occupancy = CNT_W'(skid_valid_q);
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + CNT_W'(valid_q[k]);
  end
endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed and scoreboard checks of elastic_pipeline at WIDTH=8, DEPTH=3
module tb_elastic_pipeline;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    reset = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== '0) begin bad++; $display("FAIL post_reset_idle got=%0b/%0d want=0/0", out_valid, occupancy); end
  endtask

  task automatic test_streaming;
    int sent = 0;
    int got = 0;
    int first = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (sent < 10);
      in_data  = 8'(sent + 1);
      #1;
      if (c < 10) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready c=%0d got=%0b want=1", c, in_ready); end
      end
      if (out_valid) begin
        if (first < 0) first = c;
        total++; if (out_data !== 8'(got + 1)) begin bad++; $display("FAIL stream_data got=%h want=%h", out_data, 8'(got + 1)); end
        got++;
      end
      if (c >= 3 && c <= 10) begin
        total++; if (occupancy !== CNT_W'(3)) begin bad++; $display("FAIL stream_occupancy c=%0d got=%0d want=3", c, occupancy); end
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (first !== 3) begin bad++; $display("FAIL stream_latency got=%0d want=3", first); end
    total++; if (got !== 10) begin bad++; $display("FAIL stream_count got=%0d want=10", got); end
  endtask

  task automatic test_back_pressure;
    int idx = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      in_data  = 8'(16 + idx);
      #1;
      if (in_valid && in_ready) idx++;
      tick();
    end
    #1;
    total++; if (idx !== 3 + SKID) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", idx, 3 + SKID); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
    total++; if (occupancy !== CNT_W'(3 + SKID)) begin bad++; $display("FAIL bp_occupancy got=%0d want=%0d", occupancy, 3 + SKID); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin bad++; $display("FAIL bp_head got=%0b/%h want=1/10", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 4);
      in_data  = 8'(16 + idx);
      #1;
      if (out_valid) begin
        total++; if (out_data !== 8'(16 + got)) begin bad++; $display("FAIL bp_drain got=%h want=%h", out_data, 8'(16 + got)); end
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (got !== 4 || idx !== 4) begin bad++; $display("FAIL bp_count got=%0d/%0d want=4/4", got, idx); end
  endtask

  task automatic test_bubble;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0 || c == 3);
      in_data  = (c == 0) ? 8'h20 : 8'h21;
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== CNT_W'(2)) begin bad++; $display("FAIL bubble_occupancy got=%0d want=2", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin bad++; $display("FAIL bubble_head got=%0b/%h want=1/20", out_valid, out_data); end
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== CNT_W'(3)) begin bad++; $display("FAIL bubble_packed got=%0d want=3", occupancy); end
    total++; if (in_ready !== 1'(SKID)) begin bad++; $display("FAIL bubble_full_ready got=%0b want=%0d", in_ready, SKID); end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        total++; if (out_data !== 8'(32 + got)) begin bad++; $display("FAIL bubble_order got=%h want=%h", out_data, 8'(32 + got)); end
        got++;
      end
      tick();
    end
    total++; if (got !== 3) begin bad++; $display("FAIL bubble_count got=%0d want=3", got); end
  endtask

  task automatic test_flush;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(48 + c);
      tick();
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_cleared got=%0d/%0b want=0/0", occupancy, out_valid); end
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0);
      in_data  = 8'h40;
      #1;
      if (out_valid) begin
        total++; if (out_data !== 8'h40) begin bad++; $display("FAIL flush_leak got=%h want=40", out_data); end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (got !== 1) begin bad++; $display("FAIL flush_recover got=%0d want=1", got); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(96 + c);
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== CNT_W'(3) || out_valid !== 1'b1) begin bad++; $display("FAIL areset_prefill got=%0d/%0b want=3/1", occupancy, out_valid); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid got=%0b want=0", out_valid); end
    total++; if (occupancy !== '0) begin bad++; $display("FAIL areset_occupancy got=%0d want=0", occupancy); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL areset_out_data got=%h want=00", out_data); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || occupancy !== '0) begin bad++; $display("FAIL areset_release got=%0b/%0d want=1/0", in_ready, occupancy); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] q[$];
    bit took = 1'b1;
`ifdef ELASTIC_PIPE_SKID_EN
    logic r;
`endif
    in_valid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (took || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
`ifdef ELASTIC_PIPE_SKID_EN
      r = in_ready;
      out_ready = ~out_ready;
      #1;
      total++; if (in_ready !== r) begin bad++; $display("FAIL rand_ready_path c=%0d got=%0b want=%0b", c, in_ready, r); end
      out_ready = ~out_ready;
      #1;
`endif
      total++; if (occupancy !== CNT_W'(q.size())) begin bad++; $display("FAIL rand_occupancy c=%0d got=%0d want=%0d", c, occupancy, q.size()); end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rand_spurious c=%0d got=%h want=none", c, out_data); end
        else begin
          if (out_data !== q[0]) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      took = in_valid && in_ready;
      if (took) q.push_back(in_data);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rand_drain_spurious got=%h want=none", out_data); end
        else begin
          if (out_data !== q[0]) begin bad++; $display("FAIL rand_drain got=%h want=%h", out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      tick();
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rand_lost got=%0d want=0", q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
